// File: rtl/stdp_weight_update.sv
// STDP weight update stage.
// Keeps pre/post spike traces and turns spikes into LTP/LTD requests. Each
// request runs one cycle through the external add8 adder, and the result is
// committed to the weight register with saturation.
// All [0:7] buses carry index 0 as the LSB, which is the carry-chain entry.
// Internally values use normal [7:0] weighting, and the buses are mapped bit by bit.
// Handshake: upd_valid is a one-cycle, push-only strobe with no ready. It is
// high during the cycle after a weight commit, and weight holds the new value then.
module stdp_weight_update #(
  parameter logic [7:0] W_INIT    = 8'd128,
  parameter logic [7:0] TRACE_MAX = 8'd32,
  parameter int         DECAY_DIV = 4,
  parameter int         LR_SHIFT  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pre_spike,
  input  logic       post_spike,
  output logic [0:7] add_a,
  output logic [0:7] add_b,
  output logic       add_cin,
  input  logic [0:7] add_sum,
  input  logic       add_cout,
  output logic [0:7] weight,
  output logic       busy,
  output logic       upd_valid,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LTP  = 2'd1,
    S_LTD  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] w_q;
  logic [7:0] pre_trace;
  logic [7:0] post_trace;
  logic [7:0] prescaler;
  logic       tick;
  logic       pend_ltp;
  logic       pend_ltd;
  logic [7:0] dltp;
  logic [7:0] dltd;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] sum_n;

  assign tick      = (prescaler == 8'(DECAY_DIV - 1));
  assign busy      = (state != S_IDLE) || pend_ltp || pend_ltd;
  assign dbg_state = state;

  // Next state: LTP has priority from IDLE, and each update hands over to the other pending one.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (pend_ltp)      state_nx = S_LTP;
        else if (pend_ltd) state_nx = S_LTD;
        else               state_nx = S_IDLE;
      end
      S_LTP:   state_nx = pend_ltd ? S_LTD : S_IDLE;
      S_LTD:   state_nx = pend_ltp ? S_LTP : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Adder operands. LTD subtracts by adding ~delta with a carry-in of 1.
  always_comb begin
    op_a    = 8'd0;
    op_b    = 8'd0;
    add_cin = 1'b0;
    case (state)
      S_LTP: begin
        op_a = w_q;
        op_b = dltp;
      end
      S_LTD: begin
        op_a    = w_q;
        op_b    = ~dltd;
        add_cin = 1'b1;
      end
      default: begin
        op_a    = 8'd0;
        op_b    = 8'd0;
        add_cin = 1'b0;
      end
    endcase
  end

  // Bus mapping: bus index i carries numeric bit i (LSB at index 0).
  always_comb begin
    weight = '0;
    add_a  = '0;
    add_b  = '0;
    sum_n  = '0;
    for (int i = 0; i < 8; i++) begin
      weight[i] = w_q[i];
      add_a[i]  = op_a[i];
      add_b[i]  = op_b[i];
      sum_n[i]  = add_sum[i];
    end
  end

  // State register and saturating weight commit on the edge that leaves LTP/LTD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      w_q       <= W_INIT;
      upd_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      upd_valid <= 1'b0;
      if (state == S_LTP) begin
        w_q       <= add_cout ? 8'hFF : sum_n;
        upd_valid <= 1'b1;
      end else if (state == S_LTD) begin
        w_q       <= add_cout ? sum_n : 8'h00;
        upd_valid <= 1'b1;
      end
    end
  end

  // Traces: a spike reloads the trace, and a nonzero trace decays by one on each prescaler tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler  <= 8'd0;
      pre_trace  <= 8'd0;
      post_trace <= 8'd0;
    end else begin
      prescaler <= tick ? 8'd0 : prescaler + 8'd1;
      if (pre_spike)                      pre_trace <= TRACE_MAX;
      else if (tick && pre_trace != 8'd0) pre_trace <= pre_trace - 8'd1;
      if (post_spike)                       post_trace <= TRACE_MAX;
      else if (tick && post_trace != 8'd0)  post_trace <= post_trace - 8'd1;
    end
  end

  // Capture requests: a spike on the commit edge sets the flag again and refreshes the delta.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_ltp <= 1'b0;
      pend_ltd <= 1'b0;
      dltp     <= 8'd0;
      dltd     <= 8'd0;
    end else begin
      if (post_spike) begin
        pend_ltp <= 1'b1;
        dltp     <= pre_trace >> LR_SHIFT;
      end else if (state == S_LTP) begin
        pend_ltp <= 1'b0;
      end
      if (pre_spike) begin
        pend_ltd <= 1'b1;
        dltd     <= post_trace >> LR_SHIFT;
      end else if (state == S_LTD) begin
        pend_ltd <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stdp_weight_update.sv
// Testbench for stdp_weight_update. The bench supplies the add8 adder and
// checks every cycle against a request-level model of the learning rule.
module tb_stdp_weight_update;

  logic       clk;
  logic       rst;
  logic       pre_spike;
  logic       post_spike;
  logic [0:7] add_a;
  logic [0:7] add_b;
  logic       add_cin;
  logic [0:7] add_sum;
  logic       add_cout;
  logic [0:7] weight;
  logic       busy;
  logic       upd_valid;
  logic [1:0] dbg_state;

  int tests_run = 0;
  int fail_cnt  = 0;

  // Reference model state, in plain integers.
  int m_w, m_pre_tr, m_post_tr, m_ps, m_op, m_dltp, m_dltd;
  bit m_pl, m_pd, m_valid;

  stdp_weight_update dut (
    .clk(clk), .rst(rst), .pre_spike(pre_spike), .post_spike(post_spike),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .weight(weight), .busy(busy), .upd_valid(upd_valid), .dbg_state(dbg_state)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int bus_val(input logic [0:7] b);
    int v = 0;
    for (int i = 0; i < 8; i++) if (b[i] === 1'b1) v += (1 << i);
    return v;
  endfunction

  // Behavioural add8: bus index 0 is the LSB.
  always_comb begin
    int s;
    s = bus_val(add_a) + bus_val(add_b) + int'(add_cin);
    add_sum = '0;
    for (int i = 0; i < 8; i++) add_sum[i] = s[i];
    add_cout = s[8];
  end

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_w = 128; m_pre_tr = 0; m_post_tr = 0; m_ps = 0; m_op = 0;
    m_dltp = 0; m_dltd = 0; m_pl = 0; m_pd = 0; m_valid = 0;
  endtask

  // One clock of the learning rule: finish the running update, pick the next one, capture spikes, decay traces.
  task automatic model_edge(input bit pre, input bit post);
    int  op_n;
    bit  tick;
    op_n = 0;
    m_valid = 0;
    if (m_op == 1) begin
      m_w = (m_w + m_dltp > 255) ? 255 : m_w + m_dltp;
      m_valid = 1;
    end else if (m_op == 2) begin
      m_w = (m_w - m_dltd < 0) ? 0 : m_w - m_dltd;
      m_valid = 1;
    end
    if (m_op == 0)      op_n = m_pl ? 1 : (m_pd ? 2 : 0);
    else if (m_op == 1) op_n = m_pd ? 2 : 0;
    else                op_n = m_pl ? 1 : 0;
    if (post) begin m_pl = 1; m_dltp = m_pre_tr / 4; end
    else if (m_op == 1) m_pl = 0;
    if (pre) begin m_pd = 1; m_dltd = m_post_tr / 4; end
    else if (m_op == 2) m_pd = 0;
    tick = (m_ps == 3);
    if (pre) m_pre_tr = 32; else if (tick && m_pre_tr > 0) m_pre_tr--;
    if (post) m_post_tr = 32; else if (tick && m_post_tr > 0) m_post_tr--;
    m_ps = (m_ps + 1) % 4;
    m_op = op_n;
  endtask

  task automatic check_all(input string tag);
    int ea, eb;
    ea = (m_op != 0) ? m_w : 0;
    eb = (m_op == 1) ? m_dltp : ((m_op == 2) ? (255 - m_dltd) : 0);
    check({tag, ".weight"},    9'(bus_val(weight)), 9'(m_w));
    check({tag, ".upd_valid"}, {8'd0, upd_valid},   {8'd0, m_valid});
    check({tag, ".busy"},      {8'd0, busy},        9'((m_op != 0) || m_pl || m_pd));
    check({tag, ".add_a"},     9'(bus_val(add_a)),  9'(ea));
    check({tag, ".add_b"},     9'(bus_val(add_b)),  9'(eb));
    check({tag, ".add_cin"},   {8'd0, add_cin},     9'(m_op == 2));
  endtask

  task automatic step(input string tag, input bit pre, input bit post);
    pre_spike  = pre;
    post_spike = post;
    @(posedge clk);
    model_edge(pre, post);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    pre_spike = 1'b0;
    post_spike = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // Pre then post spike: LTD with a zero delta, then LTP of +8.
    step("pair", 1, 0);
    step("pair", 0, 1);
    repeat (4) step("pair", 0, 0);
    check("pair.w136", 9'(bus_val(weight)), 9'd136);

    // Drive the weight up to the 255 clamp.
    step("sat", 1, 0);
    repeat (30) begin
      step("sat", 0, 1);
      step("sat", 0, 0);
      step("sat", 0, 0);
    end
    repeat (4) step("sat", 0, 0);
    check("sat.w255", 9'(bus_val(weight)), 9'd255);

    // Drive the weight down to the 0 clamp.
    repeat (8) begin
      step("borrow", 0, 1);
      repeat (10) begin
        step("borrow", 1, 0);
        step("borrow", 0, 0);
        step("borrow", 0, 0);
      end
    end
    repeat (4) step("borrow", 0, 0);
    check("borrow.w0", 9'(bus_val(weight)), 9'd0);

    // Simultaneous spikes with both traces freshly loaded.
    repeat (4) begin
      step("sim.pre", 1, 1);
      repeat (6) step("sim.pre", 0, 0);
    end
    step("sim", 1, 1);
    repeat (5) step("sim", 0, 0);

    // Reset asserted while an LTP update is running.
    step("rstmid", 0, 1);
    step("rstmid", 0, 0);
    check("rstmid.in_ltp", {8'd0, add_cin}, 9'd0);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("rstmid");
    #2 rst = 1'b0;
    repeat (3) step("rstmid.after", 0, 0);

    // Random spike traffic.
    repeat (400) step("rand", ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0));
    repeat (6) step("drain", 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
